// File: rtl/nx_axi4s_msg_unpack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : nx_axi4s_msg_unpack                                             |
// | Function : Unpacks valid 32-bit lanes of a buffered AXI4-stream beat into   |
// |            one 31-bit Nexus message per cycle, with message/frame counters. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module nx_axi4s_msg_unpack #(
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int AXI4_STRB_WIDTH = AXI4_DATA_WIDTH/8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [AXI4_DATA_WIDTH-1:0] ib_axi4s_tdata_i,
  input  logic [AXI4_STRB_WIDTH-1:0] ib_axi4s_tkeep_i,
  input  logic                       ib_axi4s_tlast_i,
  input  logic                       ib_axi4s_tvalid_i,
  output logic                       ib_axi4s_tready_o,
  output logic [30:0]                ob_nx_data_o,
  output logic                       ob_nx_last_o,
  output logic                       ob_nx_valid_o,
  input  logic                       ob_nx_ready_i,
  output logic [31:0]                msg_count_o,
  output logic [31:0]                frame_count_o,
  output logic                       err_keep_o
);

  localparam int LANES = AXI4_DATA_WIDTH/32;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t                 r_state;
  logic [LANES-1:0][30:0] r_data;
  logic [LANES-1:0]       r_mask;
  logic                   r_last;
  logic                   r_active;
  logic                   r_err;
  logic [31:0]            r_msg_cnt;
  logic [31:0]            r_frame_cnt;

  logic [LANES-1:0]       w_lane_vld;
  logic [LANES-1:0]       w_lane_part;
  logic [LANES-1:0][30:0] w_lane_msg;
  logic [LANES-1:0]       w_low;
  logic [30:0]            w_data;
  logic                   w_onehot;
  logic                   w_valid;
  logic                   w_hs;
  logic                   w_acc;
  logic                   w_tready;

  generate
    for (genvar n = 0; n < LANES; n++) begin : g_lane
      logic [3:0] w_keep;
      assign w_keep         = ib_axi4s_tkeep_i[4*n +: 4];
      assign w_lane_vld[n]  = (w_keep == 4'hF) & ib_axi4s_tdata_i[32*n+31];
      assign w_lane_part[n] = (w_keep != 4'h0) & (w_keep != 4'hF);
      assign w_lane_msg[n]  = ib_axi4s_tdata_i[32*n +: 31];
    end
  endgenerate

  // Lowest pending lane wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    w_data = '0;
    w_low  = '0;
    for (int n = LANES-1; n >= 0; n--) begin
      if (r_mask[n]) begin
        w_data   = r_data[n];
        w_low    = '0;
        w_low[n] = 1'b1;
      end
    end
  end

  assign w_onehot = $onehot(r_mask);
  assign w_valid  = |r_mask;
  assign w_hs     = w_valid & ob_nx_ready_i;
  // r_active keeps tready low through reset without a path from rstn or tvalid.
  assign w_tready = r_active & ((r_state == S_EMPTY) | (w_onehot & ob_nx_ready_i));
  assign w_acc    = ib_axi4s_tvalid_i & w_tready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_EMPTY;
      r_data      <= '0;
      r_mask      <= '0;
      r_last      <= 1'b0;
      r_active    <= 1'b0;
      r_err       <= 1'b0;
      r_msg_cnt   <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_active <= 1'b1;
      if (w_hs) begin
        r_mask    <= r_mask & ~w_low;
        r_msg_cnt <= r_msg_cnt + 32'd1;
      end
      if (w_acc) begin
        r_data  <= w_lane_msg;
        r_mask  <= w_lane_vld;
        r_last  <= ib_axi4s_tlast_i;
        r_state <= (|w_lane_vld) ? S_DRAIN : S_EMPTY;
        if (ib_axi4s_tlast_i) r_frame_cnt <= r_frame_cnt + 32'd1;
        if (|w_lane_part)     r_err       <= 1'b1;
      end else if (w_hs && w_onehot) begin
        r_state <= S_EMPTY;
      end
    end
  end

  assign ib_axi4s_tready_o = w_tready;
  assign ob_nx_valid_o     = w_valid;
  assign ob_nx_data_o      = w_data;
  assign ob_nx_last_o      = r_last & w_onehot;
  assign msg_count_o       = r_msg_cnt;
  assign frame_count_o     = r_frame_cnt;
  assign err_keep_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_nx_axi4s_msg_unpack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_nx_axi4s_msg_unpack                                          |
// | Function : Directed self-checking bench for nx_axi4s_msg_unpack.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_nx_axi4s_msg_unpack;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [127:0] tdata = '0;
  logic [15:0]  tkeep = '0;
  logic         tlast = 1'b0;
  logic         tvalid = 1'b0;
  logic         tready;
  logic [30:0]  nx_data;
  logic         nx_last;
  logic         nx_valid;
  logic         nx_ready = 1'b1;
  logic [31:0]  msg_cnt;
  logic [31:0]  frame_cnt;
  logic         err_keep;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [30:0] got_d[$];
  logic        got_l[$];
  int          got_c[$];
  logic [30:0] exp_d[$];
  logic        exp_l[$];

  nx_axi4s_msg_unpack dut (
    .clk               (clk),
    .rstn              (rstn),
    .ib_axi4s_tdata_i  (tdata),
    .ib_axi4s_tkeep_i  (tkeep),
    .ib_axi4s_tlast_i  (tlast),
    .ib_axi4s_tvalid_i (tvalid),
    .ib_axi4s_tready_o (tready),
    .ob_nx_data_o      (nx_data),
    .ob_nx_last_o      (nx_last),
    .ob_nx_valid_o     (nx_valid),
    .ob_nx_ready_i     (nx_ready),
    .msg_count_o       (msg_cnt),
    .frame_count_o     (frame_cnt),
    .err_keep_o        (err_keep)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rstn && nx_valid && nx_ready) begin
      got_d.push_back(nx_data);
      got_l.push_back(nx_last);
      got_c.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_msg(input logic [30:0] d, input logic l);
    exp_d.push_back(d);
    exp_l.push_back(l);
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l,
                           output int acc_cyc);
    bit acc = 0;
    tdata = d; tkeep = k; tlast = l; tvalid = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (tready) acc = 1;
      @(posedge clk); #1;
    end
    if (acc) acc_cyc = cyc - 1;
    else     check("accept_timeout", 64'd0, 64'd1);
    tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge clk);
      if (!nx_valid && tready) idle = 1;
    end
    if (!idle) check("idle_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic compare_msgs(input string tag);
    check({tag, "_count"}, 64'(got_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), 64'(got_d[i]), 64'(exp_d[i]));
      check($sformatf("%s_last%0d", tag, i), 64'(got_l[i]), 64'(exp_l[i]));
    end
    got_d.delete(); got_l.delete(); got_c.delete();
    exp_d.delete(); exp_l.delete();
  endtask

  initial begin
    int a1, a2, c0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", 64'(tready), 64'd0);
    check("rst_valid", 64'(nx_valid), 64'd0);
    check("rst_last", 64'(nx_last), 64'd0);
    check("rst_data", 64'(nx_data), 64'd0);
    check("rst_msg", 64'(msg_cnt), 64'd0);
    check("rst_frame", 64'(frame_cnt), 64'd0);
    check("rst_err", 64'(err_keep), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("rel_tready", 64'(tready), 64'd1);

    // Single full beat
    send_beat({32'h80000004, 32'h80000003, 32'h80000002, 32'h80000001}, 16'hFFFF, 1'b1, a1);
    wait_idle();
    for (int i = 0; i < 4 && i < got_c.size(); i++)
      check($sformatf("single_cyc%0d", i), 64'(got_c[i]), 64'(a1 + 1 + i));
    expect_msg(31'h1, 0); expect_msg(31'h2, 0); expect_msg(31'h3, 0); expect_msg(31'h4, 1);
    compare_msgs("single");
    check("single_msg", 64'(msg_cnt), 64'd4);
    check("single_frame", 64'(frame_cnt), 64'd1);

    // Sparse lanes: lane1 bit31 clear, lane3 keep 0
    send_beat({32'h80000055, 32'h8000000B, 32'h0000000C, 32'h8000000A}, 16'h0FFF, 1'b0, a1);
    wait_idle();
    expect_msg(31'hA, 0); expect_msg(31'hB, 0);
    compare_msgs("sparse");
    check("sparse_err", 64'(err_keep), 64'd0);
    check("sparse_msg", 64'(msg_cnt), 64'd6);

    // Zero-lane tlast beat while EMPTY: consumed in one cycle, counted as frame
    c0 = cyc;
    send_beat({4{32'h00000001}}, 16'h0000, 1'b1, a1);
    check("zero_acc_cyc", 64'(a1), 64'(c0));
    wait_idle();
    compare_msgs("zero");
    check("zero_frame", 64'(frame_cnt), 64'd2);

    // Back-to-back beats
    send_beat({32'h80000014, 32'h80000013, 32'h80000012, 32'h80000011}, 16'hFFFF, 1'b0, a1);
    send_beat({32'h80000024, 32'h80000023, 32'h80000022, 32'h80000021}, 16'hFFFF, 1'b1, a2);
    check("b2b_accept_gap", 64'(a2 - a1), 64'd4);
    wait_idle();
    for (int i = 0; i < 8 && i < got_c.size(); i++)
      check($sformatf("b2b_cyc%0d", i), 64'(got_c[i]), 64'(a1 + 1 + i));
    for (int i = 1; i <= 4; i++) expect_msg(31'(32'h10 + i), 0);
    for (int i = 1; i <= 4; i++) expect_msg(31'(32'h20 + i), i == 4);
    compare_msgs("b2b");
    check("b2b_msg", 64'(msg_cnt), 64'd14);
    check("b2b_frame", 64'(frame_cnt), 64'd3);

    // Backpressure: ready 1,0,0,1
    send_beat({32'h80000034, 32'h80000033, 32'h80000032, 32'h80000031}, 16'hFFFF, 1'b0, a1);
    @(posedge clk); #1;
    nx_ready = 1'b0;
    check("bp_data_a", 64'(nx_data), 64'h32);
    check("bp_valid_a", 64'(nx_valid), 64'd1);
    @(posedge clk); #1;
    check("bp_data_b", 64'(nx_data), 64'h32);
    check("bp_msg_b", 64'(msg_cnt), 64'd15);
    @(posedge clk); #1;
    check("bp_data_c", 64'(nx_data), 64'h32);
    nx_ready = 1'b1;
    wait_idle();
    for (int i = 1; i <= 4; i++) expect_msg(31'(32'h30 + i), 0);
    compare_msgs("bp");
    check("bp_msg", 64'(msg_cnt), 64'd18);

    // Partial keep on lane2, then a clean beat
    send_beat({32'h80000044, 32'h80000043, 32'h80000042, 32'h80000041}, 16'hF3FF, 1'b0, a1);
    wait_idle();
    expect_msg(31'h41, 0); expect_msg(31'h42, 0); expect_msg(31'h44, 0);
    compare_msgs("partial");
    check("partial_err", 64'(err_keep), 64'd1);
    send_beat({32'h80000054, 32'h80000053, 32'h80000052, 32'h80000051}, 16'hFFFF, 1'b1, a1);
    wait_idle();
    for (int i = 1; i <= 4; i++) expect_msg(31'(32'h50 + i), i == 4);
    compare_msgs("clean");
    check("clean_err_sticky", 64'(err_keep), 64'd1);
    check("clean_msg", 64'(msg_cnt), 64'd25);
    check("clean_frame", 64'(frame_cnt), 64'd4);

    // Reset after two of four messages delivered
    send_beat({32'h80000064, 32'h80000063, 32'h80000062, 32'h80000061}, 16'hFFFF, 1'b1, a1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    check("mrst_valid", 64'(nx_valid), 64'd0);
    check("mrst_msg", 64'(msg_cnt), 64'd0);
    check("mrst_frame", 64'(frame_cnt), 64'd0);
    check("mrst_err", 64'(err_keep), 64'd0);
    check("mrst_tready", 64'(tready), 64'd0);
    expect_msg(31'h61, 0); expect_msg(31'h62, 0);
    compare_msgs("mrst_pre");
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mrst_residual", 64'(got_d.size()), 64'd0);
    check("mrst_valid_post", 64'(nx_valid), 64'd0);
    send_beat({32'h80000074, 32'h80000073, 32'h80000072, 32'h80000071}, 16'hFFFF, 1'b1, a1);
    wait_idle();
    for (int i = 1; i <= 4; i++) expect_msg(31'(32'h70 + i), i == 4);
    compare_msgs("fresh");
    check("fresh_msg", 64'(msg_cnt), 64'd4);
    check("fresh_frame", 64'(frame_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
